conv_seq_ctrl: RTL

Sequencer for the convolution datapath.
- On a start command it fetches the 9 packed kernel words from input SRAM and presents them as two 16-bit kernel vectors.
- It then streams a configurable run of ifmap words from input SRAM to the conv engine under a valid/ready handshake.
- It generates output-SRAM write addresses from the engine's dout_valid, and reports busy/done/abort to the ICB register block.

---
 rtl/conv_seq_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: job sequencer for the convolution datapath.
// Ports: clk/rst_n; start/abort + cfg_* from the register block;
//   sram_rd_* to input SRAM; kernel_num_*/weight_vld and
//   conv_num/conv_num_valid/conv_ready/conv_done to the conv engine;
//   dout_valid in, ofmap_wr_en/ofmap_addr out; busy/done/aborted status.
module conv_seq_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int NTAP   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    cfg_wbase,
    input  logic [ADDR_W-1:0]    cfg_ibase,
    input  logic [ADDR_W-1:0]    cfg_ilen,
    input  logic [ADDR_W-1:0]    cfg_obase,
    output logic                 sram_rd_en,
    output logic [ADDR_W-1:0]    sram_rd_addr,
    input  logic [DATA_W-1:0]    sram_rd_data,
    output logic [NTAP*16-1:0]   kernel_num_1,
    output logic [NTAP*16-1:0]   kernel_num_2,
    output logic                 weight_vld,
    output logic [DATA_W-1:0]    conv_num,
    output logic                 conv_num_valid,
    input  logic                 conv_ready,
    input  logic                 conv_done,
    input  logic                 dout_valid,
    output logic                 ofmap_wr_en,
    output logic [ADDR_W-1:0]    ofmap_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam int CW = $clog2(NTAP + 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   wbase_q, ibase_q, ilen_q;
    logic [CW-1:0]       wcnt_q;
    logic [ADDR_W-1:0]   iss_q, xf_q, oaddr_q;
    logic [1:0]          cred_q, fcnt_q;
    logic                go_q, wpend_q, spend_q, cdone_q;
    logic                wp_q, rp_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic [15:0]         k1_q [NTAP];
    logic [15:0]         k2_q [NTAP];
    logic                wvld_q, done_q, abt_q;

    logic                rd_w, rd_s, fifo_ne, vld, xfer, push, pop, last;
    logic [DATA_W-1:0]   head;

    // Stream reads start one cycle after STREAM entry (go_q) so that the
    // FIFO bypass keeps each credit busy for only two cycles: issue, then
    // the transfer of the returned word. Two credits then sustain one
    // word per cycle.
    always_comb begin
        rd_w    = (state_q == LOAD_W) && (wcnt_q < CW'(NTAP));
        rd_s    = (state_q == STREAM) && go_q && (cred_q != 2'd0)
                  && (iss_q != ilen_q);
        fifo_ne = (fcnt_q != 2'd0);
        vld     = fifo_ne || spend_q;
        head    = fifo_ne ? fifo_q[rp_q] : sram_rd_data;
        xfer    = vld && conv_ready;
        push    = spend_q && (fifo_ne || !conv_ready);
        pop     = xfer && fifo_ne;
        last    = xfer && (xf_q == ilen_q - ONE);
    end

    assign sram_rd_en     = rd_w || rd_s;
    assign sram_rd_addr   = rd_w ? wbase_q + ADDR_W'(wcnt_q) :
                            rd_s ? ibase_q + iss_q : '0;
    assign conv_num_valid = vld;
    assign conv_num       = vld ? head : '0;
    assign weight_vld     = wvld_q;
    assign ofmap_wr_en    = dout_valid;
    assign ofmap_addr     = oaddr_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign aborted        = abt_q;

    for (genvar k = 0; k < NTAP; k++) begin : g_k
        assign kernel_num_1[16*k +: 16] = k1_q[k];
        assign kernel_num_2[16*k +: 16] = k2_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wbase_q <= '0;
            ibase_q <= '0;
            ilen_q  <= '0;
            wcnt_q  <= '0;
            iss_q   <= '0;
            xf_q    <= '0;
            oaddr_q <= '0;
            cred_q  <= 2'd2;
            fcnt_q  <= 2'd0;
            go_q    <= 1'b0;
            wpend_q <= 1'b0;
            spend_q <= 1'b0;
            cdone_q <= 1'b0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            for (int k = 0; k < NTAP; k++) begin
                k1_q[k] <= '0;
                k2_q[k] <= '0;
            end
            wvld_q  <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            abt_q  <= abort;
            done_q <= 1'b0;

            if (state_q == IDLE && start && !abort)
                oaddr_q <= cfg_obase;
            else if (dout_valid)
                oaddr_q <= oaddr_q + ONE;
            else if (state_q == IDLE)
                oaddr_q <= cfg_obase;

            if (abort) begin
                state_q <= IDLE;
                if (state_q != IDLE)
                    wvld_q <= 1'b0;
                go_q    <= 1'b0;
                wpend_q <= 1'b0;
                spend_q <= 1'b0;
                cdone_q <= 1'b0;
                cred_q  <= 2'd2;
                fcnt_q  <= 2'd0;
                wp_q    <= 1'b0;
                rp_q    <= 1'b0;
            end else begin
                wpend_q <= rd_w;
                spend_q <= rd_s;
                go_q    <= (state_q == STREAM);
                cred_q  <= cred_q - {1'b0, rd_s} + {1'b0, xfer};
                fcnt_q  <= fcnt_q + {1'b0, push} - {1'b0, pop};
                if (push) begin
                    fifo_q[wp_q] <= sram_rd_data;
                    wp_q         <= ~wp_q;
                end
                if (pop)
                    rp_q <= ~rp_q;
                if (rd_s)
                    iss_q <= iss_q + ONE;
                if (xfer)
                    xf_q <= xf_q + ONE;
                for (int k = 0; k < NTAP; k++) begin
                    if (wpend_q && wcnt_q == CW'(k + 1)) begin
                        k1_q[k] <= sram_rd_data[15:0];
                        k2_q[k] <= sram_rd_data[31:16];
                    end
                end
                // An early conv_done is remembered for DRAIN.
                if ((state_q == STREAM || state_q == DRAIN) && conv_done)
                    cdone_q <= 1'b1;

                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= LOAD_W;
                            wbase_q <= cfg_wbase;
                            ibase_q <= cfg_ibase;
                            ilen_q  <= cfg_ilen;
                            wvld_q  <= 1'b0;
                            wcnt_q  <= '0;
                            iss_q   <= '0;
                            xf_q    <= '0;
                            cdone_q <= 1'b0;
                        end
                    end
                    LOAD_W: begin
                        if (wcnt_q == CW'(NTAP)) begin
                            wvld_q <= 1'b1;
                            if (ilen_q == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= STREAM;
                            end
                        end else begin
                            wcnt_q <= wcnt_q + CW'(1);
                        end
                    end
                    STREAM: begin
                        if (last)
                            state_q <= DRAIN;
                    end
                    DRAIN: begin
                        if (conv_done || cdone_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
